// File: rtl/issue_buff_ooo.sv
// Out-of-order issue buffer: an age-ordered collapsing queue of micro-ops.
// Each cycle it issues the oldest entry whose producer tags are all done.
// With IN_ORDER=1 only the head (slot 0) may issue.
module issue_buff_ooo #(
    parameter  int DATA_WIDTH = 47,
    parameter  int ELEMENTS   = 4,
    parameter  int TAG_COUNT  = 10,
    parameter  int IN_ORDER   = 0,
    localparam int CW         = $clog2(ELEMENTS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [TAG_COUNT-1:0]  din_wait,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    input  logic [TAG_COUNT-1:0]  done_flags,
    input  logic                  flush,
    output logic [CW-1:0]         count
);

    localparam int IW = (ELEMENTS > 1) ? $clog2(ELEMENTS) : 1;

    // Slot i is valid exactly when i < count, since valid slots are
    // always contiguous from slot 0.
    logic [DATA_WIDTH-1:0] data_q [ELEMENTS];
    logic [TAG_COUNT-1:0]  wait_q [ELEMENTS];

    logic [ELEMENTS-1:0] slot_ready;
    logic [IW-1:0]       sel;
    logic                sel_found;
    logic                iss;
    logic                enq;
    logic [CW-1:0]       wr_idx;

    // Per-slot readiness: valid and every waited tag currently done.
    always_comb begin
        for (int i = 0; i < ELEMENTS; i++) begin
            slot_ready[i] = (CW'(i) < count) && ((wait_q[i] & ~done_flags) == '0);
        end
    end

    // Pick the oldest ready slot, or only the head in in-order mode.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        sel       = '0;
        sel_found = 1'b0;
        if (IN_ORDER != 0) begin
            sel_found = slot_ready[0];
        end else begin
            for (int i = ELEMENTS - 1; i >= 0; i--) begin
                if (slot_ready[i]) begin
                    sel       = IW'(i);
                    sel_found = 1'b1;
                end
            end
        end
    end

    assign dout       = data_q[sel];
    assign dout_valid = sel_found & ~flush & ~rst;
    assign din_ready  = (count < CW'(ELEMENTS)) & ~flush & ~rst;
    assign iss        = dout_valid & dout_ready;
    assign enq        = din_valid & din_ready;
    // A same-cycle issue frees one slot, so the new entry lands one lower.
    assign wr_idx     = count - CW'(iss);

    // Payload/mask storage: collapse above the issued slot, then append.
    always_ff @(posedge clk) begin
        // NOTE: the storage arrays are not reset; validity lives entirely in count, and skipping the reset keeps the arrays mappable to plain registers/RAM.
        for (int i = 0; i < ELEMENTS - 1; i++) begin
            if (iss && IW'(i) >= sel) begin
                data_q[i] <= data_q[i + 1];
                wait_q[i] <= wait_q[i + 1];
            end
        end
        // The enqueue write comes last so it overrides any shift into the same slot.
        for (int i = 0; i < ELEMENTS; i++) begin
            if (enq && CW'(i) == wr_idx) begin
                data_q[i] <= din;
                wait_q[i] <= din_wait;
            end
        end
    end

    // Occupancy counter; reset and flush both empty the queue.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
        if (rst || flush) begin
            count <= '0;
        end else begin
            count <= count + CW'(enq) - CW'(iss);
        end
    end

endmodule

// File: tb/tb_issue_buff_ooo.sv
// Directed self-checking bench for issue_buff_ooo. Two instances share all
// inputs: one in oldest-ready mode, one in strict in-order mode.
module tb_issue_buff_ooo;

    localparam int DW = 47;
    localparam int EL = 4;
    localparam int TC = 10;
    localparam int CW = $clog2(EL + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] din;
    logic [TC-1:0] din_wait;
    logic          din_valid;
    logic          dout_ready;
    logic [TC-1:0] done_flags;
    logic          flush;

    logic [DW-1:0] o_dout,  i_dout;
    logic          o_dv,    i_dv;
    logic          o_dinr,  i_dinr;
    logic [CW-1:0] o_cnt,   i_cnt;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [DW-1:0] PA = 47'h0000_0000_0AAA;
    localparam logic [DW-1:0] PB = 47'h0000_0000_0BBB;
    localparam logic [DW-1:0] PC = 47'h0000_0000_0CCC;
    localparam logic [DW-1:0] PD = 47'h0000_0000_0DDD;
    localparam logic [DW-1:0] PE = 47'h4000_0000_0E00;
    localparam logic [DW-1:0] PF = 47'h0000_0000_0FFF;
    localparam logic [DW-1:0] PP = 47'h1234_5678_0001;
    localparam logic [DW-1:0] PQ = 47'h1234_5678_0002;
    localparam logic [DW-1:0] PS = 47'h7654_3210_0005;

    always #5 clk = ~clk;

    issue_buff_ooo #(.DATA_WIDTH(DW), .ELEMENTS(EL), .TAG_COUNT(TC), .IN_ORDER(0)) u_ooo (
        .clk(clk), .rst(rst), .din(din), .din_wait(din_wait), .din_valid(din_valid),
        .din_ready(o_dinr), .dout(o_dout), .dout_valid(o_dv), .dout_ready(dout_ready),
        .done_flags(done_flags), .flush(flush), .count(o_cnt)
    );

    issue_buff_ooo #(.DATA_WIDTH(DW), .ELEMENTS(EL), .TAG_COUNT(TC), .IN_ORDER(1)) u_ino (
        .clk(clk), .rst(rst), .din(din), .din_wait(din_wait), .din_valid(din_valid),
        .din_ready(i_dinr), .dout(i_dout), .dout_valid(i_dv), .dout_ready(dout_ready),
        .done_flags(done_flags), .flush(flush), .count(i_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Let combinational outputs settle after inputs change (mid low phase).
    task automatic settle();
        #1;
    endtask

    // Advance through one rising edge to the next falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic push(input logic [DW-1:0] d, input logic [TC-1:0] w);
        din       = d;
        din_wait  = w;
        din_valid = 1'b1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; din = '0; din_wait = '0;
        din_valid = 1'b1; dout_ready = 1'b0; done_flags = '0;

        // ---- reset held for two cycles with din_valid high ----
        step();
        settle();
        check("rst_cnt",      o_cnt, 0);
        check("rst_dv",       o_dv, 0);
        check("rst_dinr",     o_dinr, 0);
        check("rst_io_dinr",  i_dinr, 0);
        step();
        rst = 1'b0; din_valid = 1'b0;
        settle();
        check("post_rst_dinr", o_dinr, 1);
        check("post_rst_cnt",  o_cnt, 0);
        check("post_rst_dv",   o_dv, 0);
        check("post_rst_io_dinr", i_dinr, 1);

        // ---- out-of-order issue (and in-order comparison) ----
        dout_ready = 1'b1;
        step();
        push(PA, 10'h001);
        settle();
        check("ooo_empty_dv", o_dv, 0);
        step();
        push(PB, 10'h000);
        settle();
        check("ooo_a_blocked", o_dv, 0);
        check("ooo_cnt1", o_cnt, 1);
        step();
        push(PC, 10'h000);
        settle();
        check("ooo_b_dv",   o_dv, 1);
        check("ooo_b_dout", o_dout, PB);
        check("io_b_blocked", i_dv, 0);
        step();
        din_valid = 1'b0;
        settle();
        check("ooo_c_dout", o_dout, PC);
        check("ooo_c_cnt",  o_cnt, 2);
        check("io_cnt3",    i_cnt, 3);
        check("io_c_blocked", i_dv, 0);
        step();
        settle();
        check("ooo_only_a_dv", o_dv, 0);
        check("ooo_only_a_cnt", o_cnt, 1);
        done_flags = 10'h001;
        settle();
        check("ooo_a_dout", o_dout, PA);
        check("io_a_dout",  i_dout, PA);
        check("io_a_dv",    i_dv, 1);
        step();
        settle();
        check("ooo_drained_cnt", o_cnt, 0);
        check("ooo_drained_dv",  o_dv, 0);
        check("io_b_dout", i_dout, PB);
        check("io_b_cnt",  i_cnt, 2);
        step();
        settle();
        check("io_c_dout", i_dout, PC);
        check("io_c_cnt",  i_cnt, 1);
        step();
        settle();
        check("io_drained_cnt", i_cnt, 0);
        check("io_drained_dv",  i_dv, 0);

        // ---- full queue and backpressure ----
        done_flags = '0; dout_ready = 1'b0;
        for (int i = 0; i < EL; i++) begin
            push(PE + DW'(i), 10'h002);
            step();
        end
        push(PF, 10'h000);
        settle();
        check("full_cnt",  o_cnt, 4);
        check("full_dinr", o_dinr, 0);
        check("full_dv",   o_dv, 0);
        din_valid = 1'b0;
        done_flags = 10'h3FF;
        settle();
        check("full_hold_dv",   o_dv, 1);
        check("full_hold_dout", o_dout, PE);
        step();
        settle();
        check("full_hold2_dout", o_dout, PE);
        check("full_hold2_cnt",  o_cnt, 4);
        dout_ready = 1'b1;
        push(PF, 10'h000);
        settle();
        check("full_iss_dinr", o_dinr, 0);
        step();
        din_valid = 1'b0; dout_ready = 1'b0;
        settle();
        check("full_after_cnt",  o_cnt, 3);
        check("full_after_dout", o_dout, PE + 47'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        settle();
        check("flush1_cnt", o_cnt, 0);

        // ---- simultaneous enqueue and issue at count=2 ----
        done_flags = '0;
        push(PP, 10'h000);
        step();
        push(PQ, 10'h000);
        step();
        push(PD, 10'h000);
        dout_ready = 1'b1;
        settle();
        check("sim_p_dout", o_dout, PP);
        check("sim_dinr",   o_dinr, 1);
        step();
        din_valid = 1'b0;
        settle();
        check("sim_cnt",    o_cnt, 2);
        check("sim_q_dout", o_dout, PQ);
        step();
        settle();
        check("sim_d_dout", o_dout, PD);
        check("sim_d_cnt",  o_cnt, 1);
        step();
        settle();
        check("sim_end_cnt", o_cnt, 0);

        // ---- flush mid-stream ----
        flush = 1'b1;
        step();
        flush = 1'b0; dout_ready = 1'b0; done_flags = '0;
        push(PA, 10'h008);
        step();
        push(PB, 10'h000);
        step();
        push(PC, 10'h008);
        step();
        settle();
        check("fl_pre_cnt", o_cnt, 3);
        flush = 1'b1; dout_ready = 1'b1;
        push(PF, 10'h000);
        settle();
        check("fl_dv",   o_dv, 0);
        check("fl_dinr", o_dinr, 0);
        step();
        flush = 1'b0;
        push(PS, 10'h000);
        settle();
        check("fl_cnt",    o_cnt, 0);
        check("fl_dv_mt",  o_dv, 0);
        step();
        din_valid = 1'b0;
        settle();
        check("fl_s_cnt",  o_cnt, 1);
        check("fl_s_dv",   o_dv, 1);
        check("fl_s_dout", o_dout, PS);
        step();
        settle();
        check("fl_end_cnt", o_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/issue_buff_ooo.md
# issue_buff_ooo

Parametrised out-of-order issue buffer. It holds up to ELEMENTS dispatched micro-ops, each tagged with a mask of producer tags it waits on. Every cycle it issues the oldest entry whose waited tags are all done. Storage is an age-ordered collapsing queue. A mode parameter restores strict head-only (in-order) issue, so the block is a drop-in replacement for the sequential issue buffer when the dependency mask is driven.

## Interface
- DATA_WIDTH, 47, width of the stored micro-op payload.
- ELEMENTS, 4, queue depth; legal range 2..16.
- TAG_COUNT, 10, number of completion tags / width of done_flags and dependency masks.
- IN_ORDER, 0, 1 means only slot 0 (oldest) may issue; 0 means oldest-ready selection.
- CW (localparam), $clog2(ELEMENTS+1), occupancy counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- din  in  DATA_WIDTH  payload to enqueue.
- din_wait  in  TAG_COUNT  tags this payload depends on (bit i set = waits on tag i).
- din_valid  in  1  enqueue request.
- din_ready  out  1  buffer can accept this cycle.
- dout  out  DATA_WIDTH  payload of selected entry (combinational from storage).
- dout_valid  out  1  a ready entry is selected.
- dout_ready  in  1  consumer accepts dout.
- done_flags  in  TAG_COUNT  level flags; bit i high = tag i result available.
- flush  in  1  discard all entries (branch mispredict / pipeline restart).
- count  out  CW  current occupancy.

## Operation
- Storage: slots 0..ELEMENTS-1, each with valid, payload, wait mask. Valid slots are always contiguous from slot 0; slot 0 is the oldest.
- Entry ready: valid and (wait & ~done_flags) == 0, evaluated combinationally on the stored mask.
- Selection, IN_ORDER=0: the lowest-index ready slot (priority encoder). IN_ORDER=1: slot 0 only, and only if it is ready.
- dout_valid = any selected slot and !flush and !rst. dout shows the selected payload; it is don't-care when dout_valid=0.
- Issue (dout_valid & dout_ready): selected slot k is removed. Slots k+1..count-1 each shift down one position, keeping payload and mask. Order is preserved.
- din_ready = (count < ELEMENTS) & !rst & !flush. There is no full-bypass: a full queue refuses input even if an issue happens the same cycle.
- Enqueue (din_valid & din_ready): payload and din_wait are written to slot count, or to slot count-1 if an issue also occurs this cycle.
- Simultaneous enqueue and issue: count is unchanged; the new entry lands behind all survivors.
- Wait masks are never modified. Readiness tracks done_flags live, so a flag deasserting makes its dependent entries not ready again.
- flush: all valids cleared and count set to 0 at the edge. din is not accepted and no issue occurs that cycle.
- rst: same effect as flush. It takes priority over flush and over any handshake.
- Out of reset: count=0, din_ready=1 (after rst deasserts), dout_valid=0.

## Timing
- Enqueue to earliest issue is 1 cycle: an entry accepted at edge N can present dout_valid in cycle N+1 if its mask is already satisfied. It is never visible in the cycle it is written.
- done_flags to dout_valid is combinational, with zero added latency.
- dout_valid may drop without a handshake only because of flush, rst, or done_flags deasserting. Otherwise the selected entry is held until accepted. However, an older entry becoming ready may change the selection before acceptance; the consumer samples dout only on the handshake cycle.
- Throughput is one issue and one enqueue per cycle.
- count updates on the edge: count + enq - iss.

## Test plan
- Reset: assert rst for 2 cycles with din_valid=1 -> count=0, dout_valid=0, din_ready=0 during rst; din_ready=1 on the first cycle after.
- Out-of-order issue: enqueue A (wait 0x001), B (wait 0x000), C (wait 0x000), with done_flags=0 and dout_ready=1 -> issue order B then C. Then raise flag 0 -> A issues; count ends at 0.
- IN_ORDER=1: same stimulus -> nothing issues until flag 0 rises, then A, B, C issue on consecutive cycles.
- Full/backpressure: ELEMENTS=4, fill with 4 unready entries -> din_ready=0, count=4. Raise all flags with dout_ready=0 -> dout shows entry 0, held stable. Then dout_ready=1 with din_valid=1 on the same cycle -> issue occurs, no enqueue, count=3.
- Simultaneous enqueue and issue at count=2 (slot 0 ready): new entry D lands in slot 1, count stays 2, and the next issue order is the old slot 1 then D.
- Flush mid-stream: 3 entries, one ready, flush=1 with dout_ready=1 and din_valid=1 -> no handshake in either direction; count=0 next cycle; a subsequent enqueue is issued normally.
